frame_sched: RTL and testbench

Per-frame update scheduler for the Pong game logic. It detects the start of vertical blanking and walks a fixed list of game-logic clients (key sampling, paddle move, ball move, collision/score) through a req/ack handshake, one client at a time in index order. Frame state therefore only changes while nothing is being drawn. It sits between the `vsync` blanking output and the game-logic units feeding `img_generator`.

---
 rtl/frame_sched.sv | 90 +++++++++
 tb/tb_frame_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sched.sv
// frame_sched: vblank-triggered req/ack sequencer walking game-logic clients once per frame
module frame_sched #(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT = 1024,
  parameter int FRAME_DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_vblank,
  input  logic                 i_enable,
  input  logic [N_CLIENTS-1:0] i_ack,
  input  logic                 i_clr_err,
  output logic [N_CLIENTS-1:0] o_req,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overrun,
  output logic [N_CLIENTS-1:0] o_err,
  output logic [15:0]          o_frame_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic vb_q, arm_q, busy_q, done_q, ovr_q;
  logic [7:0] div_q;
  logic [15:0] timer_q, cnt_q;
  logic [N_CLIENTS-1:0] req_q, err_q, err_set;
  logic rise, run_ok, hit, tmo;
  // arm_q blocks a vblank already high at reset release from looking like a rising edge
  always_comb begin
    rise = i_vblank & ~vb_q & arm_q;
    run_ok = (state_q == RUN) & i_vblank;
    hit = |(i_ack & req_q);
    tmo = timer_q == 16'(TIMEOUT - 1);
    err_set = (run_ok & ~hit & tmo) ? req_q : '0;
  end
  // sequencer: one-hot request walk, all outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      vb_q <= 1'b0;
      arm_q <= 1'b0;
      div_q <= '0;
      timer_q <= '0;
      cnt_q <= '0;
      req_q <= '0;
      err_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vb_q <= i_vblank;
      arm_q <= arm_q | ~i_vblank;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      err_q <= (i_clr_err ? '0 : err_q) | err_set;
      if (rise) div_q <= (div_q == 8'(FRAME_DIV - 1)) ? '0 : div_q + 8'd1;
      if (state_q == IDLE) begin
        if (rise && div_q == '0 && i_enable) begin
          state_q <= RUN;
          req_q <= N_CLIENTS'(1);
          busy_q <= 1'b1;
          timer_q <= '0;
        end
      end else if (!i_vblank) begin
        state_q <= IDLE;
        req_q <= '0;
        busy_q <= 1'b0;
        ovr_q <= 1'b1;
      end else if (hit || tmo) begin
        timer_q <= '0;
        if (req_q[N_CLIENTS-1]) begin
          state_q <= IDLE;
          req_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt_q <= cnt_q + 16'd1;
        end else begin
          req_q <= req_q << 1;
        end
      end else if (timer_q != 16'hFFFF) begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end
  assign o_req = req_q;
  assign o_busy = busy_q;
  assign o_frame_done = done_q;
  assign o_overrun = ovr_q;
  assign o_err = err_q;
  assign o_frame_cnt = cnt_q;
endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: scoreboard bench for frame_sched (main instance plus a FRAME_DIV=3 instance)
module tb_frame_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vb = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic [3:0] ack = 4'h0;
  logic [3:0] req, err;
  logic busy, done, ovr;
  logic [15:0] cnt;
  logic vb2 = 1'b0;
  logic en2 = 1'b1;
  logic clr2 = 1'b0;
  logic [3:0] ack2 = 4'hF;
  logic [3:0] req2, err2;
  logic busy2, done2, ovr2;
  logic [15:0] cnt2;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ev = 0;
  logic mon_en = 1'b0;
  logic [26:0] prev, snap;
  typedef struct {int dt; logic [26:0] v;} ev_t;
  ev_t q[$];
  ev_t e;
  logic [15:0] dexp [18] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3,
                             16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd5, 16'd5, 16'd5};

  frame_sched #(.N_CLIENTS(4), .TIMEOUT(16), .FRAME_DIV(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vblank(vb), .i_enable(en), .i_ack(ack), .i_clr_err(clr),
    .o_req(req), .o_busy(busy), .o_frame_done(done), .o_overrun(ovr), .o_err(err), .o_frame_cnt(cnt)
  );

  frame_sched #(.N_CLIENTS(4), .TIMEOUT(16), .FRAME_DIV(3)) u_div (
    .i_clk(clk), .i_rst_n(rst_n), .i_vblank(vb2), .i_enable(en2), .i_ack(ack2), .i_clr_err(clr2),
    .o_req(req2), .o_busy(busy2), .o_frame_done(done2), .o_overrun(ovr2), .o_err(err2), .o_frame_cnt(cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(int dt, logic [3:0] r, logic b, logic d, logic o, logic [3:0] er, logic [15:0] c);
    q.push_back('{dt, {r, b, d, o, er, c}});
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic serve(logic [1:0] idx, int delay);
    int n = 0;
    while (!req[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req[idx]) begin
      checks++;
      failures++;
      $display("FAIL serve%0d no request within bound", idx);
    end else begin
      repeat (delay - 1) @(negedge clk);
      ack[idx] = 1'b1;
      @(negedge clk);
      ack[idx] = 1'b0;
    end
  endtask

  // monitor: every change of the output snapshot must match the next queued expectation
  always @(negedge clk) begin
    snap = {req, busy, done, ovr, err, cnt};
    if (mon_en && snap !== prev) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got req=%b busy=%b done=%b ovr=%b err=%b cnt=%0d cyc=%0d",
                 snap[26:23], snap[22], snap[21], snap[20], snap[19:16], snap[15:0], cyc);
      end else begin
        e = q.pop_front();
        if (snap !== e.v || (e.dt >= 0 && cyc - last_ev != e.dt)) begin
          failures++;
          $display("FAIL event got req=%b busy=%b done=%b ovr=%b err=%b cnt=%0d dt=%0d expected req=%b busy=%b done=%b ovr=%b err=%b cnt=%0d dt=%0d",
                   snap[26:23], snap[22], snap[21], snap[20], snap[19:16], snap[15:0], cyc - last_ev,
                   e.v[26:23], e.v[22], e.v[21], e.v[20], e.v[19:16], e.v[15:0], e.dt);
        end
      end
    end
    if (!mon_en || snap !== prev) last_ev = cyc;
    prev = snap;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'({req, busy, done, ovr, err, cnt}), 32'd0);
    chk("reset_state_div", 32'({req2, busy2, done2, ovr2, err2, cnt2}), 32'd0);
    mon_en = 1'b1;
    // divider: pulses 1,4,7,10,16 start a sequence; pulse 13 is suppressed by enable
    for (int p = 0; p < 18; p++) begin
      en2 = (p != 12);
      vb2 = 1'b1;
      repeat (10) @(negedge clk);
      vb2 = 1'b0;
      en2 = 1'b1;
      repeat (5) @(negedge clk);
      chk($sformatf("div_pulse%0d", p + 1), 32'(cnt2), 32'(dexp[p]));
    end
    // normal frame, each client acks 3 cycles after its request
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd0);
    push(3, 4'b0010, 1, 0, 0, 4'b0000, 16'd0);
    push(3, 4'b0100, 1, 0, 0, 4'b0000, 16'd0);
    push(3, 4'b1000, 1, 0, 0, 4'b0000, 16'd0);
    push(3, 4'b0000, 0, 1, 0, 4'b0000, 16'd1);
    push(1, 4'b0000, 0, 0, 0, 4'b0000, 16'd1);
    vb = 1'b1;
    serve(2'd0, 3);
    serve(2'd1, 3);
    serve(2'd2, 3);
    serve(2'd3, 3);
    repeat (5) @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    // client 2 times out after 16 cycles, then error clear
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd1);
    push(1, 4'b0010, 1, 0, 0, 4'b0000, 16'd1);
    push(1, 4'b0100, 1, 0, 0, 4'b0000, 16'd1);
    push(16, 4'b1000, 1, 0, 0, 4'b0100, 16'd1);
    push(1, 4'b0000, 0, 1, 0, 4'b0100, 16'd2);
    push(1, 4'b0000, 0, 0, 0, 4'b0100, 16'd2);
    vb = 1'b1;
    serve(2'd0, 1);
    serve(2'd1, 1);
    serve(2'd3, 1);
    repeat (3) @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    push(-1, 4'b0000, 0, 0, 0, 4'b0000, 16'd2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    // overrun: client 1 withholds ack, vblank falls
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd2);
    push(1, 4'b0010, 1, 0, 0, 4'b0000, 16'd2);
    push(11, 4'b0000, 0, 0, 1, 4'b0000, 16'd2);
    push(1, 4'b0000, 0, 0, 0, 4'b0000, 16'd2);
    vb = 1'b1;
    serve(2'd0, 1);
    repeat (10) @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    // stray ack ignored, ack in timeout cycle gives no error
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd2);
    push(2, 4'b0010, 1, 0, 0, 4'b0000, 16'd2);
    push(16, 4'b0100, 1, 0, 0, 4'b0000, 16'd2);
    push(1, 4'b1000, 1, 0, 0, 4'b0000, 16'd2);
    push(1, 4'b0000, 0, 1, 0, 4'b0000, 16'd3);
    push(1, 4'b0000, 0, 0, 0, 4'b0000, 16'd3);
    vb = 1'b1;
    @(negedge clk);
    ack = 4'b1000;
    @(negedge clk);
    ack = 4'b0000;
    serve(2'd0, 1);
    serve(2'd1, 16);
    serve(2'd2, 1);
    serve(2'd3, 1);
    repeat (3) @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    // all clients ack immediately: 4-cycle sequence
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd3);
    push(1, 4'b0010, 1, 0, 0, 4'b0000, 16'd3);
    push(1, 4'b0100, 1, 0, 0, 4'b0000, 16'd3);
    push(1, 4'b1000, 1, 0, 0, 4'b0000, 16'd3);
    push(1, 4'b0000, 0, 1, 0, 4'b0000, 16'd4);
    push(1, 4'b0000, 0, 0, 0, 4'b0000, 16'd4);
    ack = 4'b1111;
    vb = 1'b1;
    repeat (8) @(negedge clk);
    vb = 1'b0;
    ack = 4'b0000;
    repeat (3) @(negedge clk);
    // async reset during step 2, released with vblank still high
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd4);
    push(1, 4'b0010, 1, 0, 0, 4'b0000, 16'd4);
    push(1, 4'b0100, 1, 0, 0, 4'b0000, 16'd4);
    push(-1, 4'b0000, 0, 0, 0, 4'b0000, 16'd0);
    vb = 1'b1;
    serve(2'd0, 1);
    serve(2'd1, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({req, busy, done, ovr, cnt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_restart", 32'({req, busy}), 32'd0);
    push(-1, 4'b0001, 1, 0, 0, 4'b0000, 16'd0);
    push(1, 4'b0010, 1, 0, 0, 4'b0000, 16'd0);
    push(1, 4'b0100, 1, 0, 0, 4'b0000, 16'd0);
    push(1, 4'b1000, 1, 0, 0, 4'b0000, 16'd0);
    push(1, 4'b0000, 0, 1, 0, 4'b0000, 16'd1);
    push(1, 4'b0000, 0, 0, 0, 4'b0000, 16'd1);
    ack = 4'b1111;
    vb = 1'b0;
    repeat (3) @(negedge clk);
    vb = 1'b1;
    repeat (8) @(negedge clk);
    vb = 1'b0;
    ack = 4'b0000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
